// File: rtl/cell_selector.sv
// Cursor/commit controller for a tic-tac-toe style board: steps a cursor over free cells,
// commits the cell under it, and tracks turns, per-turn timeout and board-full.
module cell_selector #(
  parameter int N_CELLS        = 9,
  parameter int POS_W          = 4,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TO_W           = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               btn_next,
  input  logic               btn_sel,
  input  logic [N_CELLS-1:0] occupied,
  output logic [POS_W-1:0]   pos,
  output logic               ready,
  output logic               player,
  output logic               timeout,
  output logic               board_full
);

  typedef enum logic [1:0] {SEARCH, IDLE, COMMIT, FULL} state_t;

  localparam logic [POS_W-1:0] LAST    = POS_W'(N_CELLS - 1);
  localparam bit               TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_W-1:0]  TO_LAST = TO_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           state, state_nxt;
  logic [POS_W-1:0] pos_nxt, pos_inc;
  logic [POS_W-1:0] scan_cnt, scan_nxt;
  logic             player_nxt;
  logic [TO_W-1:0]  timer, timer_nxt;
  logic             prev_next, prev_sel;
  logic             next_edge, sel_edge;
  logic             cur_occ;
  logic             timeout_hit;

  // Previous levels are sampled even while disabled so a held button never yields a late edge.
  assign next_edge = btn_next & ~prev_next;
  assign sel_edge  = btn_sel & ~prev_sel;

  assign cur_occ     = occupied[pos];
  assign pos_inc     = (pos == LAST) ? '0 : pos + POS_W'(1);
  assign timeout_hit = TO_EN && enable && (state == IDLE) && (timer == TO_LAST) && !sel_edge;

  always_comb begin
    state_nxt  = state;
    pos_nxt    = pos;
    scan_nxt   = scan_cnt;
    player_nxt = player;
    timer_nxt  = timer;
    if (enable) begin
      case (state)
        SEARCH: begin
          if (!cur_occ) begin
            state_nxt = IDLE;
          end else begin
            // After N occupied cells the cursor has wrapped back to where the scan began.
            pos_nxt = pos_inc;
            if (scan_cnt == LAST) state_nxt = FULL;
            else                  scan_nxt  = scan_cnt + POS_W'(1);
          end
        end
        IDLE: begin
          if (TO_EN) timer_nxt = timer + TO_W'(1);
          if (sel_edge) begin
            if (!cur_occ) begin
              state_nxt = COMMIT;
            end else begin
              state_nxt = SEARCH;
              scan_nxt  = '0;
            end
          end else begin
            if (timeout_hit) begin
              timer_nxt  = '0;
              player_nxt = ~player;
            end
            if (next_edge) begin
              pos_nxt   = pos_inc;
              state_nxt = SEARCH;
              scan_nxt  = '0;
            end else if (cur_occ) begin
              state_nxt = SEARCH;
              scan_nxt  = '0;
            end
          end
        end
        COMMIT: begin
          player_nxt = ~player;
          timer_nxt  = '0;
          state_nxt  = SEARCH;
          scan_nxt   = '0;
        end
        FULL: begin
          if (!(&occupied)) begin
            state_nxt = SEARCH;
            scan_nxt  = '0;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      pos       <= '0;
      scan_cnt  <= '0;
      player    <= 1'b0;
      timer     <= '0;
      prev_next <= 1'b0;
      prev_sel  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pos       <= pos_nxt;
      scan_cnt  <= scan_nxt;
      player    <= player_nxt;
      timer     <= timer_nxt;
      prev_next <= btn_next;
      prev_sel  <= btn_sel;
    end
  end

  assign ready      = enable && (state == COMMIT);
  assign timeout    = timeout_hit;
  assign board_full = (state == FULL) && (&occupied);

endmodule

// File: tb/tb_cell_selector.sv
// Directed bench for cell_selector: commits are scored against a queue of expected
// (pos, player) pairs; a second instance exercises the per-turn timeout.
module tb_cell_selector;
  localparam int N = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b1;
  logic         btn_next = 1'b0;
  logic         btn_sel = 1'b0;
  logic [N-1:0] occupied = '0;
  logic [3:0]   pos;
  logic         ready, player, timeout, board_full;

  logic [N-1:0] to_occ = '0;
  logic         to_btn = 1'b0;
  logic [3:0]   to_pos;
  logic         to_ready, to_player, to_timeout, to_full;

  typedef struct packed {logic [3:0] pos; logic player;} exp_t;
  exp_t sb[$];
  int passes = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cell_selector #(.N_CELLS(N), .POS_W(4), .TIMEOUT_CYCLES(0), .TO_W(32)) dut (
    .clk(clk), .reset(rst), .enable(enable), .btn_next(btn_next), .btn_sel(btn_sel),
    .occupied(occupied), .pos(pos), .ready(ready), .player(player),
    .timeout(timeout), .board_full(board_full));

  cell_selector #(.N_CELLS(N), .POS_W(4), .TIMEOUT_CYCLES(20), .TO_W(8)) dut_to (
    .clk(clk), .reset(rst), .enable(1'b1), .btn_next(to_btn), .btn_sel(to_btn),
    .occupied(to_occ), .pos(to_pos), .ready(to_ready), .player(to_player),
    .timeout(to_timeout), .board_full(to_full));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] next_free(input int start, input logic [N-1:0] occ);
    for (int i = 0; i < N; i++) begin
      int c = (start + i) % N;
      if (!occ[c]) return 4'(c);
    end
    return 4'(start);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_next();
    btn_next = 1'b1;
    tick(1);
    btn_next = 1'b0;
    tick(6);
  endtask

  task automatic push_exp(input logic [3:0] p, input logic pl);
    exp_t e;
    e.pos    = p;
    e.player = pl;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
  endtask

  // Commit monitor: every ready pulse must match the oldest expected commit.
  always @(negedge clk) begin
    exp_t e;
    if (ready) begin
      if (sb.size() == 0) begin
        check("ready_without_commit", ready, 0);
      end else begin
        e = sb.pop_front();
        check("ready_pos", pos, e.pos);
        check("ready_player", player, e.player);
      end
    end
  end

  initial begin
    int n;
    logic [3:0] exp_pos;

    tick(2);
    check("rst_pos", pos, 0);
    check("rst_ready", ready, 0);
    check("rst_player", player, 0);
    check("rst_timeout", timeout, 0);
    check("rst_board_full", board_full, 0);
    rst = 1'b0;

    // Turn timeout: 20 cycles after IDLE entry, then again 20 cycles later.
    n = 0;
    do begin tick(1); n++; end while (!to_timeout && n < 60);
    check("timeout_first_latency", n, 20);
    check("timeout_player_during_pulse", to_player, 0);
    n = 0;
    do begin
      tick(1);
      n++;
      if (n == 1) begin
        check("timeout_player_toggled", to_player, 1);
        check("timeout_one_cycle", to_timeout, 0);
      end
    end while (!to_timeout && n < 60);
    check("timeout_second_latency", n, 20);
    tick(1);
    check("timeout_player_back", to_player, 0);

    // Cursor stepping over an empty board, wrapping modulo N.
    for (int i = 1; i <= N; i++) begin
      press_next();
      check("next_step_pos", pos, i % N);
    end

    // Skip occupied cells, then commit.
    occupied = 9'b000001110;
    do_reset();
    check("start_pos", pos, 0);
    press_next();
    exp_pos = next_free(1, occupied);
    check("search_settle_pos", pos, exp_pos);
    push_exp(exp_pos, 1'b0);
    btn_sel = 1'b1;
    tick(1);
    btn_sel = 1'b0;
    occupied[exp_pos] = 1'b1;
    tick(1);
    check("commit_player_toggle", player, 1);
    check("commit_ready_dropped", ready, 0);
    tick(5);
    check("search_after_commit", pos, next_free(int'(exp_pos), occupied));

    // Simultaneous next and select: select wins, cursor stays.
    occupied = '0;
    do_reset();
    press_next();
    press_next();
    check("pos_before_both", pos, 2);
    push_exp(4'd2, 1'b0);
    btn_next = 1'b1;
    btn_sel  = 1'b1;
    tick(1);
    btn_next = 1'b0;
    btn_sel  = 1'b0;
    tick(1);
    check("both_player_toggle", player, 1);
    tick(4);
    check("both_no_advance", pos, 2);

    // Reset during the commit cycle with select held.
    btn_sel = 1'b1;
    tick(1);
    rst = 1'b1;
    #1;
    check("rst_commit_ready", ready, 0);
    check("rst_commit_pos", pos, 0);
    check("rst_commit_player", player, 0);
    tick(2);
    rst = 1'b0;
    tick(6);
    check("held_sel_no_commit_player", player, 0);
    check("held_sel_pos", pos, 0);
    btn_sel = 1'b0;
    tick(2);

    // Disabled: freeze, and a held button does not act once re-enabled.
    enable = 1'b0;
    btn_sel = 1'b1;
    btn_next = 1'b1;
    tick(1);
    btn_next = 1'b0;
    tick(3);
    check("disabled_pos_frozen", pos, 0);
    check("disabled_ready", ready, 0);
    enable = 1'b1;
    tick(6);
    check("reenable_held_sel_player", player, 0);
    check("reenable_pos", pos, 0);
    btn_sel = 1'b0;
    tick(2);
    press_next();
    check("edges_after_enable", pos, 1);
    press_next();
    check("pos_before_full", pos, 2);

    // Board full: detection, ignored buttons, recovery on new game.
    occupied = '1;
    n = 0;
    do begin tick(1); n++; end while (!board_full && n < 2 * N);
    check("full_detected", board_full, 1);
    check("full_pos", pos, 2);
    btn_next = 1'b1;
    btn_sel  = 1'b1;
    tick(1);
    btn_next = 1'b0;
    btn_sel  = 1'b0;
    tick(3);
    check("full_buttons_ignored_pos", pos, 2);
    check("full_held", board_full, 1);
    occupied = '0;
    #1;
    check("full_drop_same_cycle", board_full, 0);
    tick(4);
    check("full_exit_pos", pos, 2);

    check("scoreboard_drained", sb.size(), 0);
    check("to_instance_no_commit", to_ready, 0);
    check("to_instance_not_full", to_full, 0);
    check("to_instance_pos", to_pos, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
